// File: rtl/mem_slot_scheduler_pkg.sv
// mac_mem_pkg: shared types and constants for the SDRAM slot scheduler.
//   owner_t      : owner of one 8-clock memory cycle
//   SLOT_*       : positions in the fixed 4-slot rotation
//   STAGE_*      : bus stage numbers with a fixed meaning
//   rr_next      : successor in the three-way dio -> int -> ext rotation
package mac_mem_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CPU   = 3'd1,
        VIDEO = 3'd2,
        DISK  = 3'd3,
        DIO   = 3'd4
    } owner_t;

    localparam logic [1:0] SLOT_CPU0   = 2'd0;
    localparam logic [1:0] SLOT_VIDEO  = 2'd1;
    localparam logic [1:0] SLOT_CPU1   = 2'd2;
    localparam logic [1:0] SLOT_SHARED = 2'd3;

    localparam logic [2:0] STAGE_SYNC  = 3'd0;
    localparam logic [2:0] STAGE_MID   = 3'd4;
    localparam logic [2:0] STAGE_LATCH = 3'd7;

    // Requester index 0 = dio, 1 = internal floppy, 2 = external floppy.
    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

endpackage

// File: rtl/mem_slot_scheduler_if.sv
// Bundle of requests in and stage/strobe/ownership outputs of the scheduler.
//   master : requester side (CPU glue, video, floppy DMA, download writer)
//   slave  : scheduler side
interface mem_slot_scheduler_if;
    logic       turbo;
    logic       video_req;
    logic [1:0] dsk_req;
    logic       dio_req;
    logic [2:0] stage;
    logic [1:0] slot;
    logic       cep;
    logic       cen;
    logic       cel;
    logic       cepix;
    logic       cpu_bus;
    logic       video_bus;
    logic       dsk_bus;
    logic       dio_bus;
    logic       dsk_sel;
    logic [1:0] dsk_done;
    logic       dio_done;

    modport master (
        output turbo, video_req, dsk_req, dio_req,
        input  stage, slot, cep, cen, cel, cepix,
        input  cpu_bus, video_bus, dsk_bus, dio_bus, dsk_sel, dsk_done, dio_done
    );

    modport slave (
        input  turbo, video_req, dsk_req, dio_req,
        output stage, slot, cep, cen, cel, cepix,
        output cpu_bus, video_bus, dsk_bus, dio_bus, dsk_sel, dsk_done, dio_done
    );
endinterface

// File: rtl/mem_slot_scheduler_shared_slot_rr.sv
// shared_slot_rr: picks the owner of the shared slot (slot 3) and keeps the
// round-robin pointer.
//   clk_sys, reset : clock, synchronous active-high reset
//   commit_i       : decision edge for a shared slot; pointer advances here
//   turbo_i        : an unclaimed shared slot goes to the CPU instead of idle
//   dio_req_i      : download writer request
//   dsk_req_i      : floppy DMA requests, [0] internal, [1] external
//   owner_o        : proposed owner for the shared slot
//   drive_o        : floppy that gets the slot when owner_o is DISK
module shared_slot_rr
    import mac_mem_pkg::*;
#(
    parameter bit DIO_PRIORITY = 1'b1
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       commit_i,
    input  logic       turbo_i,
    input  logic       dio_req_i,
    input  logic [1:0] dsk_req_i,
    output owner_t     owner_o,
    output logic       drive_o
);

    // ptr_q is the requester to look at first: with DIO_PRIORITY only bit 0
    // is used (preferred drive), otherwise it indexes dio/int/ext.
    logic [1:0] ptr_q, ptr_d;
    logic [3:0] req4;
    logic [1:0] cand;
    logic [1:0] grant;
    logic       found;

    assign req4 = {1'b0, dsk_req_i, dio_req_i};

    always_comb begin
        owner_o = turbo_i ? CPU : IDLE;
        drive_o = 1'b0;
        ptr_d   = ptr_q;
        cand    = ptr_q;
        grant   = 2'd0;
        found   = 1'b0;
        if (DIO_PRIORITY) begin
            if (dio_req_i) begin
                owner_o = DIO;
            end else if (dsk_req_i != 2'b00) begin
                owner_o = DISK;
                drive_o = (dsk_req_i == 2'b11) ? ptr_q[0] : dsk_req_i[1];
                ptr_d   = {1'b0, ~drive_o};
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (!found && req4[cand]) begin
                    found = 1'b1;
                    grant = cand;
                end
                cand = rr_next(cand);
            end
            if (found) begin
                owner_o = (grant == 2'd0) ? DIO : DISK;
                drive_o = (grant == 2'd2);
                ptr_d   = rr_next(grant);
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            ptr_q <= 2'd0;
        end else if (commit_i) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mem_slot_scheduler.sv
// mem_slot_scheduler: time-division owner of the single SDRAM port.
// Runs the 8-phase bus stage counter, the 4-slot rotation and decides at
// stage 7 who owns the next 8-clock memory cycle.
//   clk_sys, reset : clock, synchronous active-high reset
//   bus (slave)    : requests in; stage, slot, strobes, one-hot owner,
//                    dsk_sel and done pulses out
//
// stage | meaning
// 0     | cycle start, new owner valid, cep
// 4     | mid-cycle, cen
// 7     | cel, done pulse for dio/disk owner, next-owner decision
module mem_slot_scheduler
    import mac_mem_pkg::*;
#(
    parameter bit DIO_PRIORITY = 1'b1
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    mem_slot_scheduler_if.slave  bus
);

    logic [2:0] stage_q, stage_d;
    logic [1:0] slot_q, slot_d;
    owner_t     owner_q, owner_d;
    logic       dsk_sel_q, dsk_sel_d;
    logic       decide;
    logic       run;
    logic [1:0] next_slot;
    owner_t     rr_owner;
    logic       rr_drive;

    assign decide    = (stage_q == STAGE_LATCH);
    assign next_slot = slot_q + 2'd1;
    assign run       = !reset;

    shared_slot_rr #(.DIO_PRIORITY(DIO_PRIORITY)) u_shared_slot_rr (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .commit_i  (decide && (next_slot == SLOT_SHARED)),
        .turbo_i   (bus.turbo),
        .dio_req_i (bus.dio_req),
        .dsk_req_i (bus.dsk_req),
        .owner_o   (rr_owner),
        .drive_o   (rr_drive)
    );

    always_comb begin
        stage_d   = stage_q + 3'd1;
        slot_d    = slot_q;
        owner_d   = owner_q;
        dsk_sel_d = dsk_sel_q;
        if (decide) begin
            slot_d = next_slot;
            case (next_slot)
                SLOT_VIDEO:  owner_d = (bus.video_req || !bus.turbo) ? VIDEO : CPU;
                SLOT_SHARED: begin
                    owner_d = rr_owner;
                    if (rr_owner == DISK) dsk_sel_d = rr_drive;
                end
                default:     owner_d = CPU;
            endcase
        end
    end

    // Slot 0 is unconditionally CPU, so reset preloads that owner; the
    // outputs are masked while reset is held, which makes the first clock
    // after release show cpu_bus without an extra decision.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            stage_q   <= STAGE_SYNC;
            slot_q    <= SLOT_CPU0;
            owner_q   <= CPU;
            dsk_sel_q <= 1'b0;
        end else begin
            stage_q   <= stage_d;
            slot_q    <= slot_d;
            owner_q   <= owner_d;
            dsk_sel_q <= dsk_sel_d;
        end
    end

    assign bus.stage     = stage_q;
    assign bus.slot      = slot_q;
    assign bus.cep       = run && (stage_q == STAGE_SYNC);
    assign bus.cen       = run && (stage_q == STAGE_MID);
    assign bus.cel       = run && (stage_q == STAGE_LATCH);
    assign bus.cepix     = run && (stage_q[1:0] == 2'b00);
    assign bus.cpu_bus   = run && (owner_q == CPU);
    assign bus.video_bus = run && (owner_q == VIDEO);
    assign bus.dsk_bus   = run && (owner_q == DISK);
    assign bus.dio_bus   = run && (owner_q == DIO);
    assign bus.dsk_sel   = dsk_sel_q;
    assign bus.dsk_done  = {2{run && decide && (owner_q == DISK)}} & {dsk_sel_q, ~dsk_sel_q};
    assign bus.dio_done  = run && decide && (owner_q == DIO);

endmodule

// File: tb/tb_mem_slot_scheduler.sv
module tb_mem_slot_scheduler;
    import mac_mem_pkg::*;

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;

    mem_slot_scheduler_if bus_if ();

    mem_slot_scheduler #(.DIO_PRIORITY(1'b1)) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus_if)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic       turbo;
        logic       video;
        logic [1:0] dsk;
        logic       dio;
        int         at;
        owner_t     owner;
        logic       sel;
    } vec_t;

    typedef struct {
        owner_t owner;
        logic   sel;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    owner_t base0 [4] = '{CPU, VIDEO, CPU, IDLE};

    task automatic add(input logic t, input logic v, input logic [1:0] d, input logic io,
                       input int at, input owner_t o, input logic sel);
        vec_t e;
        e.turbo = t; e.video = v; e.dsk = d; e.dio = io;
        e.at = at; e.owner = o; e.sel = sel;
        vecs.push_back(e);
    endtask

    task automatic chk(input string name, input int tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d at %0t", name, tag, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] owner_bits(input owner_t o);
        case (o)
            CPU:     return 4'b1000;
            VIDEO:   return 4'b0100;
            DISK:    return 4'b0010;
            DIO:     return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic check_clk(input owner_t o, input logic sel, input int sl, input int st,
                             input bit in_rst, input int tag);
        logic [3:0] exp_bus, exp_str;
        logic [2:0] exp_done;
        exp_bus  = in_rst ? 4'b0000 : owner_bits(o);
        exp_str  = in_rst ? 4'b0000 : {st == 0, st == 4, st == 7, (st % 4) == 0};
        exp_done = 3'b000;
        if (!in_rst && st == 7) begin
            if (o == DIO)  exp_done[0] = 1'b1;
            if (o == DISK) exp_done[sel ? 2 : 1] = 1'b1;
        end
        chk("stage", tag, bus_if.stage, st);
        chk("slot", tag, bus_if.slot, sl);
        chk("strobes", tag, {bus_if.cep, bus_if.cen, bus_if.cel, bus_if.cepix}, exp_str);
        chk("owner", tag, {bus_if.cpu_bus, bus_if.video_bus, bus_if.dsk_bus, bus_if.dio_bus}, exp_bus);
        chk("done", tag, {bus_if.dsk_done, bus_if.dio_done}, exp_done);
        if (in_rst || o == DISK) chk("dsk_sel", tag, bus_if.dsk_sel, in_rst ? 1'b0 : sel);
    endtask

    task automatic adv();
        @(negedge clk_sys);
        #1;
    endtask

    task automatic drive(input vec_t e);
        sb_t s;
        bus_if.turbo     = e.turbo;
        bus_if.video_req = e.video;
        bus_if.dsk_req   = e.dsk;
        bus_if.dio_req   = e.dio;
        s.owner = e.owner;
        s.sel   = e.sel;
        sb_q.push_back(s);
    endtask

    task automatic run_cycle(input owner_t o, input int sl, input int tag);
        for (int s = 0; s < 8; s++) begin
            check_clk(o, 1'b0, sl, s, 1'b0, tag);
            adv();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish before 100000 ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        sb_t exp;
        bus_if.turbo     = 1'b0;
        bus_if.video_req = 1'b0;
        bus_if.dsk_req   = 2'b00;
        bus_if.dio_req   = 1'b0;

        for (int i = 0; i < 8; i++) add(0, 0, 2'b00, 0, 0, base0[i % 4], 0);
        for (int i = 0; i < 8; i++) add(1, 0, 2'b00, 0, 0, CPU, 0);
        add(1, 1, 2'b00, 0, 0, CPU, 0);   add(1, 1, 2'b00, 0, 0, VIDEO, 0);
        add(1, 1, 2'b00, 0, 0, CPU, 0);   add(1, 1, 2'b00, 0, 0, CPU, 0);
        add(0, 0, 2'b00, 0, 0, CPU, 0);   add(0, 0, 2'b00, 0, 0, VIDEO, 0);
        add(0, 0, 2'b00, 0, 0, CPU, 0);
        add(0, 0, 2'b11, 0, 0, DISK, 0);
        add(0, 0, 2'b11, 0, 0, CPU, 0);   add(0, 0, 2'b11, 0, 0, VIDEO, 0);
        add(0, 0, 2'b11, 0, 0, CPU, 0);   add(0, 0, 2'b11, 0, 0, DISK, 1);
        add(0, 0, 2'b11, 0, 0, CPU, 0);   add(0, 0, 2'b11, 0, 0, VIDEO, 0);
        add(0, 0, 2'b11, 0, 0, CPU, 0);   add(0, 0, 2'b11, 0, 0, DISK, 0);
        add(0, 0, 2'b00, 0, 7, CPU, 0);   add(0, 0, 2'b00, 0, 0, VIDEO, 0);
        add(0, 0, 2'b00, 0, 0, CPU, 0);   add(0, 0, 2'b01, 1, 0, DIO, 0);
        add(0, 0, 2'b01, 0, 7, CPU, 0);   add(0, 0, 2'b01, 0, 0, VIDEO, 0);
        add(0, 0, 2'b01, 0, 0, CPU, 0);   add(0, 0, 2'b01, 0, 0, DISK, 0);
        add(0, 0, 2'b00, 0, 7, CPU, 0);
        add(1, 0, 2'b00, 0, 2, CPU, 0);   add(1, 0, 2'b00, 0, 0, CPU, 0);
        add(1, 0, 2'b11, 1, 0, DIO, 0);
        add(1, 0, 2'b11, 0, 7, CPU, 0);   add(0, 0, 2'b11, 0, 2, VIDEO, 0);
        add(1, 0, 2'b11, 0, 2, CPU, 0);   add(1, 0, 2'b11, 0, 0, DISK, 1);
        add(1, 0, 2'b00, 0, 7, CPU, 0);   add(1, 0, 2'b00, 0, 0, CPU, 0);
        add(1, 0, 2'b00, 0, 0, CPU, 0);   add(0, 0, 2'b00, 0, 0, IDLE, 0);

        // Held reset: everything quiet.
        @(posedge clk_sys);
        for (int i = 0; i < 10; i++) begin
            adv();
            check_clk(IDLE, 1'b0, 0, 0, 1'b1, -1);
        end
        @(posedge clk_sys);
        @(negedge clk_sys);
        reset = 1'b0;
        drive(vecs[0]);
        #1;

        for (int k = 0; k < vecs.size(); k++) begin
            if (sb_q.size() == 0) begin
                chk("scoreboard_empty", k, 0, 1);
                exp.owner = IDLE;
                exp.sel   = 1'b0;
            end else begin
                exp = sb_q.pop_front();
            end
            for (int s = 0; s < 8; s++) begin
                check_clk(exp.owner, exp.sel, k % 4, s, 1'b0, k);
                if (k + 1 < vecs.size() && s == vecs[k + 1].at) drive(vecs[k + 1]);
                adv();
            end
        end
        chk("scoreboard_left", -1, sb_q.size(), 0);

        // Transient download request dropped before the decision is ignored.
        run_cycle(CPU, 0, 52);
        run_cycle(VIDEO, 1, 53);
        for (int s = 0; s < 8; s++) begin
            check_clk(CPU, 1'b0, 2, s, 1'b0, 54);
            if (s == 2) bus_if.dio_req = 1'b1;
            if (s == 5) bus_if.dio_req = 1'b0;
            adv();
        end
        run_cycle(IDLE, 3, 55);

        // Reset at stage 3 of a download cycle: no done, restart at slot 0.
        run_cycle(CPU, 0, 56);
        run_cycle(VIDEO, 1, 57);
        for (int s = 0; s < 8; s++) begin
            check_clk(CPU, 1'b0, 2, s, 1'b0, 58);
            if (s == 0) bus_if.dio_req = 1'b1;
            adv();
        end
        for (int s = 0; s < 4; s++) begin
            check_clk(DIO, 1'b0, 3, s, 1'b0, 59);
            if (s < 3) adv();
        end
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            adv();
            check_clk(IDLE, 1'b0, 0, 0, 1'b1, 60);
        end
        bus_if.dio_req = 1'b0;
        reset = 1'b0;
        #1;
        run_cycle(CPU, 0, 61);
        run_cycle(VIDEO, 1, 62);
        run_cycle(CPU, 2, 63);
        run_cycle(IDLE, 3, 64);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
